freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the period counter and the period output (min 4).
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on sig_in (min 2).
REQ-003 Port: clk  input  1  single reference clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: en  input  1  measurement enable; level-sensitive.
REQ-006 Port: sig_in  input  1  asynchronous measured signal, e.g. a divided-clock tap from the frequency divider chain.
REQ-007 Port: period  output  CNT_W  last measured period, in clk cycles between consecutive sig_in rising edges.
REQ-008 Port: valid  output  1  one-cycle pulse; period updated this cycle.
REQ-009 Port: ovf  output  1  sticky overflow flag; no edge within the counter range.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 sig_in SHALL pass through SYNC_STAGES flops plus one history flop; edge is high for one cycle when the synced value is 1 and the history value is 0.
REQ-012 FSM states: IDLE, ARM, MEAS; encoding is free; busy = (state != IDLE).
REQ-013 IDLE -> ARM when en=1; ARM -> MEAS on edge, cnt <= 0.
REQ-014 In MEAS with no edge, cnt SHALL increment by 1 per cycle.
REQ-015 In MEAS on edge: measured value = cnt+1; cnt <= 0; state stays MEAS. A sig_in of period P cycles yields P.
REQ-016 Without averaging (see REQ-025), each measured value SHALL be written to period with valid=1 in the cycle after the edge cycle.
REQ-017 Overflow: in MEAS, cnt == 2^CNT_W-2 and no edge -> ovf <= 1, state -> ARM, cnt <= 0, period unchanged, no valid.
REQ-018 Edge in the same cycle as cnt == 2^CNT_W-2: edge wins; measured value = 2^CNT_W-1; ovf unchanged.
REQ-019 en=0 in any state -> IDLE next cycle: cnt <= 0, ovf <= 0, valid <= 0, averaging state cleared, period held. An edge in that cycle is ignored.
REQ-020 period SHALL hold its value between valid pulses; valid never asserts in IDLE or ARM.
REQ-021 Minimum measurable period: 2 cycles (edge spacing limited by synchronized sig_in); no lower-bound check required.

Reset
REQ-022 rst_n=0 SHALL immediately force: state=IDLE, cnt=0, sync/history flops=0, period=0, valid=0, ovf=0, busy=0, averaging state=0.
REQ-023 Reset assertion mid-measurement SHALL discard the partial count; no valid is produced on or after deassertion until two new edges are seen.
REQ-024 After rst_n rises, the FSM SHALL behave per REQ-013 from the first clk edge.

Configuration
REQ-025 Macro FREQ_METER_AVG_EN defined: measured values are summed in a CNT_W+2-bit accumulator. On every 4th value, period <= sum>>2 (truncated) with valid=1, and the accumulator and sample count are cleared. Overflow and en=0 also clear both.
REQ-026 Macro FREQ_METER_AVG_EN undefined: no accumulator logic present; behaviour per REQ-016.

Verification
REQ-027 CNT_W=8, en=1, sig_in period 10 (5 high/5 low) -> first valid one cycle after 2nd detected edge, period=10, then valid every 10 cycles, ovf=0.
REQ-028 CNT_W=8, one sig_in rising edge then held low -> ovf=1 at 255th cycle after the edge cycle, busy=1 (ARM), no valid, period unchanged.
REQ-029 CNT_W=8, sig_in edges 255 cycles apart -> period=255, valid=1, ovf=0 (REQ-018 boundary).
REQ-030 en dropped 4 cycles after an edge in MEAS, re-raised -> busy=0 then 1, no valid until two fresh edges, ovf cleared.
REQ-031 rst_n pulsed low mid-MEAS with period=10 held -> period=0, valid=0, busy=0 asynchronously, without waiting for a clk edge.
REQ-032 FREQ_METER_AVG_EN defined, successive periods 8,8,12,12 -> exactly one valid, period=10; undefined -> four valids: 8,8,12,12.

Source files
------------

// File: rtl/freq_meter.sv
// Period meter: counts clk cycles between synchronized rising edges of sig_in.
// Define FREQ_METER_AVG_EN to report the average of every four measurements instead of each one.
module freq_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Last count that can still absorb one more cycle before the result would wrap
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   sig_edge;
    logic [CNT_W-1:0]       meas;

`ifdef FREQ_METER_AVG_EN
    logic [CNT_W+1:0]       acc_q, acc_d, acc_sum;
    logic [1:0]             nsmp_q, nsmp_d;
`endif

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    assign hist_d   = sync_q[SYNC_STAGES-1];
    assign sig_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign meas     = cnt_q + CNT_ONE;
`ifdef FREQ_METER_AVG_EN
    assign acc_sum  = acc_q + {2'b00, meas};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
`ifdef FREQ_METER_AVG_EN
        acc_d    = acc_q;
        nsmp_d   = nsmp_q;
`endif
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            ovf_d   = 1'b0;
`ifdef FREQ_METER_AVG_EN
            acc_d   = '0;
            nsmp_d  = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    cnt_d   = CNT_ZERO;
                end
                S_ARM: begin
                    cnt_d = CNT_ZERO;
                    if (sig_edge) state_d = S_MEAS;
                end
                S_MEAS: begin
                    if (sig_edge) begin
                        cnt_d = CNT_ZERO;
`ifdef FREQ_METER_AVG_EN
                        if (nsmp_q == 2'd3) begin
                            period_d = acc_sum[CNT_W+1:2];
                            valid_d  = 1'b1;
                            acc_d    = '0;
                            nsmp_d   = '0;
                        end else begin
                            acc_d  = acc_sum;
                            nsmp_d = nsmp_q + 2'd1;
                        end
`else
                        period_d = meas;
                        valid_d  = 1'b1;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        ovf_d   = 1'b1;
                        state_d = S_ARM;
                        cnt_d   = CNT_ZERO;
`ifdef FREQ_METER_AVG_EN
                        acc_d   = '0;
                        nsmp_d  = '0;
`endif
                    end else begin
                        cnt_d = meas;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            hist_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef FREQ_METER_AVG_EN
            acc_q    <= '0;
            nsmp_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
`ifdef FREQ_METER_AVG_EN
            acc_q    <= acc_d;
            nsmp_q   <= nsmp_d;
`endif
        end
    end

    assign period = period_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter (CNT_W=8); the model works from edge timestamps.
module tb_freq_meter;
    localparam int CNT_W = 8;
    localparam int MAXP  = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             valid, ovf, busy;

    freq_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .period(period), .valid(valid), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0;
    int exp_q[$];
    bit have_anchor = 0;
    int anchor = 0;
    int acc_sum = 0, acc_n = 0;
    bit ovf_m = 0;
    int last_exp = 0;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: a measurement is simply the spacing of consecutive rising edges.
    function automatic void model_meas(input int v);
`ifdef FREQ_METER_AVG_EN
        acc_sum += v;
        acc_n++;
        if (acc_n == 4) begin
            exp_q.push_back(acc_sum / 4);
            last_exp = acc_sum / 4;
            acc_sum = 0;
            acc_n = 0;
        end
`else
        exp_q.push_back(v);
        last_exp = v;
`endif
    endfunction

    function automatic void model_clear();
        have_anchor = 0;
        acc_sum = 0;
        acc_n = 0;
    endfunction

    function automatic void mark_edge();
        if (have_anchor) begin
            if (cyc - anchor <= MAXP) model_meas(cyc - anchor);
            else begin
                ovf_m = 1;
                acc_sum = 0;
                acc_n = 0;
            end
        end
        have_anchor = 1;
        anchor = cyc;
    endfunction

    function automatic int exp_ovf();
        return (ovf_m || (have_anchor && (cyc - anchor) >= 262)) ? 1 : 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int p);
        mark_edge();
        sig_in = 1'b1;
        tick(1);
        sig_in = 1'b0;
        tick(p - 1);
    endtask

    task automatic en_cycle();
        tick(8);
        en = 1'b0;
        model_clear();
        ovf_m = 0;
        tick(2);
        check("busy_after_en_low", int'(busy), 0);
        check("ovf_after_en_low", int'(ovf), 0);
        en = 1'b1;
        tick(3);
        check("busy_after_en_high", int'(busy), 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got period %0d expected no valid (t=%0t)", period, $time);
            end else begin
                check("period", int'(period), exp_q.pop_front());
            end
        end
    end

    initial begin
        tick(3);
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", int'(busy), 0);
        en = 1'b1;
        tick(3);
        check("arm_busy", int'(busy), 1);

        // steady period 10
        for (int i = 0; i < 6; i++) pulse(10);
        check("ovf_steady", int'(ovf), exp_ovf());

        // 8,8,12,12 averaging group
        en_cycle();
        pulse(8); pulse(8); pulse(12); pulse(12); pulse(20);

        // edge-wins boundary and shortest period
        en_cycle();
        pulse(255); pulse(254); pulse(2); pulse(2); pulse(2); pulse(20);
        check("ovf_boundary", int'(ovf), exp_ovf());

        // random periods
        en_cycle();
        for (int i = 0; i < 30; i++) pulse(int'($urandom_range(2, 60)));
        pulse(20);

        // single edge then silence -> overflow, back to ARM
        en_cycle();
        pulse(300);
        check("ovf_set", int'(ovf), exp_ovf());
        check("ovf_busy", int'(busy), 1);
        check("ovf_period_held", int'(period), last_exp);
        pulse(10); pulse(10); pulse(10); pulse(20);
        check("ovf_sticky", int'(ovf), exp_ovf());

        // en dropped mid-measurement
        tick(8);
        mark_edge();
        sig_in = 1'b1;
        tick(1);
        sig_in = 1'b0;
        tick(6);
        en = 1'b0;
        model_clear();
        ovf_m = 0;
        tick(2);
        check("en_drop_busy", int'(busy), 0);
        check("en_drop_ovf", int'(ovf), 0);
        check("en_drop_period_held", int'(period), last_exp);
        en = 1'b1;
        tick(2);
        check("en_raise_busy", int'(busy), 1);
        pulse(10); pulse(10); pulse(10); pulse(20);

        // asynchronous reset mid-measurement
        for (int i = 0; i < 4; i++) pulse(10);
        mark_edge();
        sig_in = 1'b1;
        tick(1);
        sig_in = 1'b0;
        tick(5);
        check("pending_before_rst", exp_q.size(), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_period", int'(period), 0);
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ovf", int'(ovf), 0);
        model_clear();
        ovf_m = 0;
        last_exp = 0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_busy", int'(busy), 1);
        pulse(10); pulse(10); pulse(10); pulse(10); pulse(10); pulse(20);

        tick(20);
        check("pending_at_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
